clk_div_sched: RTL

Sequencing and arbitration controller for the system clock divider. It accepts divide-ratio change requests from two requesters, for example the system controller and the UART prescale logic. It arbitrates between them round-robin and applies each change with a quiesce/load/settle sequence, so the divider never sees a ratio change while it is enabled. It sits between the register-file/control logic and the divider's enable and ratio inputs.

---
 rtl/clk_div_sched.sv | 132 +++++++++++++
 1 files changed

// File: rtl/clk_div_sched.sv
// clk_div_sched: round-robin arbiter and quiesce/load/settle sequencer for
// the system clock divider. Optional CLK_DIV_SCHED_SKIP_SAME_EN skips same-ratio loads.
module clk_div_sched #(
    parameter logic [7:0] DEFAULT_RATIO = 8'd32,
    parameter int         QUIESCE_CYC   = 4
) (
    input  logic       i_ref_clk,
    input  logic       i_rstn,
    input  logic       i_div_en,
    input  logic       i_req0_valid,
    input  logic [7:0] i_req0_ratio,
    output logic       o_req0_ack,
    input  logic       i_req1_valid,
    input  logic [7:0] i_req1_ratio,
    output logic       o_req1_ack,
    output logic [7:0] o_div_ratio,
    output logic       o_clk_en,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        QUIESCE,
        LOAD,
        SETTLE,
        DONE
    } state_t;

    localparam logic [7:0] Q_LAST = 8'(QUIESCE_CYC - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] pending;
    logic       gnt_id;
    logic       last;

    logic       gnt_any;
    logic       gnt_sel;
    logic [7:0] gnt_ratio;
    logic [7:0] settle_last;

    // Arbitration: a tie goes to the requester not granted last time.
    always_comb begin
        gnt_any   = i_req0_valid | i_req1_valid;
        gnt_sel   = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            gnt_sel = ~last;
        end else begin
            gnt_sel = i_req1_valid;
        end
        gnt_ratio = gnt_sel ? i_req1_ratio : i_req0_ratio;
        settle_last = (pending >= 8'd2) ? pending - 8'd1 : 8'd0;
    end

    // Next-state logic; ratios 0 and 1 settle for a single cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (gnt_any) begin
`ifdef CLK_DIV_SCHED_SKIP_SAME_EN
                    if (gnt_ratio == o_div_ratio) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = QUIESCE;
                    end
`else
                    state_nxt = QUIESCE;
`endif
                end
            end
            QUIESCE: begin
                if (cnt == Q_LAST) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt == settle_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counter, grant capture and registered divider controls.
    always_ff @(posedge i_ref_clk) begin
        if (!i_rstn) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            pending     <= DEFAULT_RATIO;
            gnt_id      <= 1'b0;
            last        <= 1'b1;
            o_div_ratio <= DEFAULT_RATIO;
            o_clk_en    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == IDLE) begin
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
            if (state == IDLE && gnt_any) begin
                pending <= gnt_ratio;
                gnt_id  <= gnt_sel;
                last    <= gnt_sel;
            end
            if (state == LOAD) begin
                o_div_ratio <= pending;
            end
            o_clk_en <= i_div_en &&
                        !(state_nxt == QUIESCE || state_nxt == LOAD);
        end
    end

    // Acks decode from DONE, so they can never be high together.
    always_comb begin
        o_busy     = (state != IDLE);
        o_req0_ack = (state == DONE) && !gnt_id;
        o_req1_ack = (state == DONE) && gnt_id;
    end

endmodule
